// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared constants and requester encoding for the write-back arbiter
package wb_arbiter_pkg;

  localparam int REG_NUM   = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - busy bits for in-flight destination registers, with set/clear and hazard lookups
module wb_scoreboard
  import wb_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy_in,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_rd,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic                 issue_ready,
  output logic                 rs1_busy,
  output logic                 rs2_busy
);

  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;

  // Set is applied after clear so it wins should both ever target one index.
  always_comb begin
    busy_d = busy_q;
    if (rdy_in) begin
      if (clr_en) begin
        busy_d[clr_rd] = 1'b0;
      end
      if (issue_valid && issue_ready && (issue_rd != '0)) begin
        busy_d[issue_rd] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign issue_ready = !busy_q[issue_rd];
  assign rs1_busy    = busy_q[rs1];
  assign rs2_busy    = busy_q[rs2];

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - shares the register-file write port between ALU and load unit; WB_RR_EN selects round-robin
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy_in,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  output logic                 issue_ready,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [LEN-1:0]       alu_data,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic [LEN-1:0]       mem_data,
  output logic                 mem_ready,
  output logic                 wb_flag,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [LEN-1:0]       wb_data
);

  logic grant_mem;

`ifdef WB_RR_EN
  // prio_q names the requester favoured on the next contested cycle; after
  // a contest it moves to the loser, so reset value mem wins the first one.
  req_e prio_q;
  req_e prio_d;

  always_comb begin
    grant_mem = mem_valid && (!alu_valid || (prio_q == REQ_MEM));
    prio_d    = prio_q;
    if (rdy_in && alu_valid && mem_valid) begin
      prio_d = grant_mem ? REQ_ALU : REQ_MEM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= REQ_MEM;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  assign grant_mem = mem_valid;
`endif

  assign mem_ready = rdy_in && grant_mem;
  assign alu_ready = rdy_in && alu_valid && !grant_mem;

  logic                 wb_flag_q, wb_flag_d;
  logic [REG_IDX_W-1:0] wb_rd_q, wb_rd_d;
  logic [LEN-1:0]       wb_data_q, wb_data_d;

  // A write to x0 completes the handshake but never raises the write enable.
  always_comb begin
    wb_flag_d = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (mem_ready) begin
      wb_flag_d = (mem_rd != '0);
      wb_rd_d   = mem_rd;
      wb_data_d = mem_data;
    end else if (alu_ready) begin
      wb_flag_d = (alu_rd != '0);
      wb_rd_d   = alu_rd;
      wb_data_d = alu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_flag_q <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      wb_flag_q <= wb_flag_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_flag = wb_flag_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;

  wb_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .rdy_in     (rdy_in),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .clr_en     (wb_flag_q),
    .clr_rd     (wb_rd_q),
    .rs1        (rs1),
    .rs2        (rs2),
    .issue_ready(issue_ready),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized scoreboard bench for wb_arbiter against a behavioural model
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy_in = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_ready;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        rs1_busy, rs2_busy;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic        wb_flag;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  wb_arbiter #(.LEN(32)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_flag(wb_flag), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [36:0] expq[$];
  logic [4:0]  alu_todo[$];
  logic [4:0]  mem_todo[$];
  bit          mbusy[32];
  bit          pres_v = 1'b0;
  logic [4:0]  pres_rd = '0;
  bit          prio_mem = 1'b1;
  bit          a_v = 1'b0, m_v = 1'b0;
  logic [4:0]  a_r = '0, m_r = '0;
  logic [31:0] a_d = '0, m_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && wb_flag) begin
        if (expq.size() == 0) begin
          chk("wb_unexpected", {27'd0, wb_rd}, 32'hFFFF_FFFF);
        end else begin
          logic [36:0] e;
          e = expq.pop_front();
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, e[36:32]});
          chk("wb_data", wb_data, e[31:0]);
        end
      end
    end
  end

  task automatic step(input bit gen);
    bit a_win, m_win, iss_ok;
    @(negedge clk);
    if (gen) begin
      if (!a_v) begin
        if (alu_todo.size() > 0 && $urandom_range(0, 1) == 1) begin
          a_v = 1'b1; a_r = alu_todo.pop_front(); a_d = $urandom;
        end else if ($urandom_range(0, 15) == 0) begin
          a_v = 1'b1; a_r = 5'd0; a_d = $urandom;
        end
      end
      if (!m_v) begin
        if (mem_todo.size() > 0 && $urandom_range(0, 1) == 1) begin
          m_v = 1'b1; m_r = mem_todo.pop_front(); m_d = $urandom;
        end else if ($urandom_range(0, 15) == 0) begin
          m_v = 1'b1; m_r = 5'd0; m_d = $urandom;
        end
      end
      rdy_in      = ($urandom_range(0, 7) != 0);
      issue_valid = $urandom_range(0, 1);
      issue_rd    = 5'($urandom_range(0, 31));
    end else begin
      rdy_in      = 1'b1;
      issue_valid = 1'b0;
    end
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    alu_valid = a_v; alu_rd = a_r; alu_data = a_d;
    mem_valid = m_v; mem_rd = m_r; mem_data = m_d;
    #1;
    m_win  = rdy_in && m_v && (!a_v || prio_mem);
    a_win  = rdy_in && a_v && !m_win;
    iss_ok = !mbusy[issue_rd];
    chk("mem_ready", {31'd0, mem_ready}, {31'd0, m_win});
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, a_win});
    chk("issue_ready", {31'd0, issue_ready}, {31'd0, iss_ok});
    chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, mbusy[rs1]});
    chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, mbusy[rs2]});
    if (rdy_in && pres_v) mbusy[pres_rd] = 1'b0;
    if (rdy_in && issue_valid && iss_ok && issue_rd != 0) begin
      mbusy[issue_rd] = 1'b1;
      if ($urandom_range(0, 1) == 1) alu_todo.push_back(issue_rd);
      else mem_todo.push_back(issue_rd);
    end
    pres_v = 1'b0;
    if (m_win) begin
      pres_v = (m_r != 0); pres_rd = m_r;
      if (m_r != 0) expq.push_back({m_r, m_d});
      m_v = 1'b0;
    end else if (a_win) begin
      pres_v = (a_r != 0); pres_rd = a_r;
      if (a_r != 0) expq.push_back({a_r, a_d});
      a_v = 1'b0;
    end
`ifdef WB_RR_EN
    if (rdy_in && alu_valid && mem_valid) prio_mem = !prio_mem;
`endif
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_wb_flag", {31'd0, wb_flag}, 32'd0);
    chk("reset_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);
    chk("reset_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("reset_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("reset_issue_ready", {31'd0, issue_ready}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      #1;
      chk("reset_rs1_busy", {31'd0, rs1_busy}, 32'd0);
    end

    for (int c = 0; c < 1500; c++) step(1'b1);
    for (int c = 0; c < 6; c++) step(1'b0);
    chk("scoreboard_drained", expq.size(), 32'd0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0;
    rdy_in = 1'b1; issue_valid = 1'b1; issue_rd = 5'd7;
    @(negedge clk);
    issue_valid = 1'b0; rs1 = 5'd7;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hDEAD_BEEF;
    #1;
    chk("busy7_set", {31'd0, rs1_busy}, 32'd1);
    chk("issue7_blocked", {31'd0, issue_ready}, 32'd0);
    chk("alu7_ready", {31'd0, alu_ready}, 32'd1);
    expq.push_back({5'd7, 32'hDEAD_BEEF});
    @(posedge clk);
    #2;
    alu_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_busy7_clear", {31'd0, rs1_busy}, 32'd0);
    chk("rst_wb_flag", {31'd0, wb_flag}, 32'd0);
    @(negedge clk);
    expq.delete();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
